// File: rtl/text_console_writer_pkg.sv
// rtl/text_console_writer_pkg.sv - shared constants and FSM encoding for the text console writer
//
// Purpose: screen geometry defaults, terminal control codes and the writer FSM
// state type, imported by text_cursor and text_console_writer.
// Ports: none (package).

package text_console_writer_pkg;

  localparam int TEXT_COLS   = 80;
  localparam int TEXT_ROWS   = 30;
  localparam int TEXT_ADDR_W = 12;

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_TILDE = 8'h7E;
  localparam logic [7:0] CH_SUBST = 8'h3F;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

endpackage

// File: rtl/text_cursor.sv
// rtl/text_cursor.sv - column/row cursor counters with linear text memory address
//
// Purpose: holds the terminal cursor and derives row*COLS+col for the writer.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   advance        move one cell right, wrapping to the next row
//   newline        col=0, row+1 (wrapping to row 0)
//   cr             col=0
//   back           col-1 when col>0
//   home           col=0, row=0 (highest priority)
//   col, row       current cursor position
//   addr           linear address of the current cursor cell

module text_cursor
  import text_console_writer_pkg::*;
#(
  parameter int COLS   = TEXT_COLS,
  parameter int ROWS   = TEXT_ROWS,
  parameter int ADDR_W = TEXT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              advance,
  input  logic              newline,
  input  logic              cr,
  input  logic              back,
  input  logic              home,
  output logic [6:0]        col,
  output logic [4:0]        row,
  output logic [ADDR_W-1:0] addr
);

  localparam logic [6:0] LAST_COL = 7'(COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

  logic [4:0]        row_inc;
  logic [ADDR_W-1:0] row_wide;
  logic [ADDR_W-1:0] row_base;

  // No scrolling: stepping past the bottom row lands back on row 0.
  assign row_inc  = (row == LAST_ROW) ? 5'd0 : row + 5'd1;
  assign row_wide = ADDR_W'(row);

  generate
    if (COLS == 80) begin : g_base_80
      // row*80 as two shifts and an add instead of a multiplier.
      assign row_base = (row_wide << 6) + (row_wide << 4);
    end else begin : g_base_mul
      assign row_base = row_wide * ADDR_W'(COLS);
    end
  endgenerate

  assign addr = row_base + ADDR_W'(col);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= 7'd0;
      row <= 5'd0;
    end else if (home) begin
      col <= 7'd0;
      row <= 5'd0;
    end else if (newline) begin
      col <= 7'd0;
      row <= row_inc;
    end else if (cr) begin
      col <= 7'd0;
    end else if (advance) begin
      if (col == LAST_COL) begin
        col <= 7'd0;
        row <= row_inc;
      end else begin
        col <= col + 7'd1;
      end
    end else if (back && (col != 7'd0)) begin
      col <= col - 7'd1;
    end
  end

endmodule

// File: rtl/text_console_writer.sv
// rtl/text_console_writer.sv - terminal-style byte interpreter driving text memory port A
//
// Purpose: accepts bytes over a valid/ready handshake, writes printable glyphs
// at the cursor, handles CR/LF/BS/FF and sweeps the whole screen on clear.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   char_in, char_valid   input byte and its valid
//   char_ready            byte accepted when char_valid & char_ready
//   clear_req             full-screen clear request (level, sampled in IDLE)
//   wea, addra, dina      text memory port A write strobe/address/data
//   cursor_col/row        current cursor position
//   busy                  high while a clear sweep runs

module text_console_writer
  import text_console_writer_pkg::*;
#(
  parameter int         COLS       = TEXT_COLS,
  parameter int         ROWS       = TEXT_ROWS,
  parameter int         ADDR_W     = TEXT_ADDR_W,
  parameter logic [7:0] CLEAR_CHAR = CH_SPACE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        char_in,
  input  logic              char_valid,
  output logic              char_ready,
  input  logic              clear_req,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [7:0]        dina,
  output logic [6:0]        cursor_col,
  output logic [4:0]        cursor_row,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);

  state_t            state;
  state_t            state_next;
  logic              wea_next;
  logic [ADDR_W-1:0] addra_next;
  logic [7:0]        dina_next;
  logic              ff_pend;
  logic              ff_pend_next;

  logic              cur_advance;
  logic              cur_newline;
  logic              cur_cr;
  logic              cur_back;
  logic              cur_home;
  logic [ADDR_W-1:0] cur_addr;

  logic              is_print;
  logic              is_high;

  assign char_ready = (state == ST_IDLE) && !clear_req;
  assign busy       = (state == ST_CLEAR);

  assign is_print = (char_in >= CH_SPACE) && (char_in <= CH_TILDE);
  assign is_high  = (char_in > CH_TILDE);

  text_cursor #(
    .COLS   (COLS),
    .ROWS   (ROWS),
    .ADDR_W (ADDR_W)
  ) u_cursor (
    .clk     (clk),
    .rst     (rst),
    .advance (cur_advance),
    .newline (cur_newline),
    .cr      (cur_cr),
    .back    (cur_back),
    .home    (cur_home),
    .col     (cursor_col),
    .row     (cursor_row),
    .addr    (cur_addr)
  );

  always_comb begin
    state_next   = state;
    wea_next     = 1'b0;
    addra_next   = addra;
    dina_next    = dina;
    ff_pend_next = 1'b0;
    cur_advance  = 1'b0;
    cur_newline  = 1'b0;
    cur_cr       = 1'b0;
    cur_back     = 1'b0;
    cur_home     = 1'b0;

    case (state)
      ST_CLEAR: begin
        if (!wea) begin
          // Only reachable right after reset: every other entry into CLEAR
          // already presents address 0 with wea high.
          wea_next   = 1'b1;
          addra_next = '0;
          dina_next  = CLEAR_CHAR;
        end else if (addra == LAST_ADDR) begin
          state_next = ST_IDLE;
          cur_home   = 1'b1;
        end else begin
          wea_next   = 1'b1;
          addra_next = addra + ADDR_W'(1);
        end
      end

      ST_IDLE: begin
        if (clear_req) begin
          state_next = ST_CLEAR;
          wea_next   = 1'b1;
          addra_next = '0;
          dina_next  = CLEAR_CHAR;
        end else if (char_valid) begin
          state_next = ST_WRITE;
          if (is_print || is_high) begin
            wea_next    = 1'b1;
            addra_next  = cur_addr;
            dina_next   = is_print ? char_in : CH_SUBST;
            cur_advance = 1'b1;
          end else begin
            case (char_in)
              CH_LF: cur_newline = 1'b1;
              CH_CR: cur_cr      = 1'b1;
              CH_BS: begin
                if (cursor_col != 7'd0) begin
                  cur_back   = 1'b1;
                  wea_next   = 1'b1;
                  addra_next = cur_addr - ADDR_W'(1);
                  dina_next  = CLEAR_CHAR;
                end
              end
              CH_FF:   ff_pend_next = 1'b1;
              default: ;
            endcase
          end
        end
      end

      ST_WRITE: begin
        if (ff_pend) begin
          state_next = ST_CLEAR;
          wea_next   = 1'b1;
          addra_next = '0;
          dina_next  = CLEAR_CHAR;
        end else begin
          state_next = ST_IDLE;
        end
      end

      default: state_next = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_CLEAR;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wea     <= 1'b0;
      addra   <= '0;
      dina    <= 8'h00;
      ff_pend <= 1'b0;
    end else begin
      wea     <= wea_next;
      addra   <= addra_next;
      dina    <= dina_next;
      ff_pend <= ff_pend_next;
    end
  end

endmodule
